// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage buffer.
// Pointer width helper keeps DEPTH=1 legal (a one-entry buffer still needs a 1-bit pointer).
package pipe_pkg;

    localparam int PIPE_W_DEFAULT = 32;

    typedef logic [31:0] perf_cnt_t;

    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready bus between two pipeline stages, seen from both ends.
// master = upstream producer plus downstream consumer (bench/stages); slave = the buffer itself.
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W_DEFAULT,
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_buf_mem.sv
// Storage array for the stage buffer: synchronous write, asynchronous read.
// Latency: written data readable after the write edge. No backpressure; caller gates we.
// Reset loads every entry with RESET_VAL so the read port never shows X.
module pipe_buf_mem #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter int               ADDR_W    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register, DEPTH x WIDTH FIFO with valid/ready on both sides, global stall and flush.
// Latency: 1 cycle push to out_valid. in_ready depends only on enable and stored count (no out_ready path).
// Backpressure: a full buffer refuses pushes even while popping. PIPE_STAGE_PERF_EN adds stall/bubble counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = PIPE_W_DEFAULT,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    pipe_stage_buf_if.slave        bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output perf_cnt_t              perf_stall,
    output perf_cnt_t              perf_bubble
`endif
);

    localparam int                PTR_W = ptr_w(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_rdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_in_ready  = enable && (r_count < CNT_W'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = enable && bus.in_valid && w_in_ready;
    assign w_pop       = enable && w_out_valid && bus.out_ready;
    // A push in the flush cycle must not land in storage.
    assign w_mem_we    = w_push && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (enable && flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    pipe_buf_mem #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (PTR_W),
        .RESET_VAL (RESET_VAL)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (w_mem_we),
        .waddr (r_wr_ptr),
        .wdata (bus.in_data),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_rdata : RESET_VAL;
    assign bus.count     = r_count;

`ifdef PIPE_STAGE_PERF_EN
    perf_cnt_t r_perf_stall;
    perf_cnt_t r_perf_bubble;

    // Saturating; flush leaves the history intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall  <= '0;
            r_perf_bubble <= '0;
        end else if (enable) begin
            if (bus.in_valid && !w_in_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (!w_out_valid && bus.out_ready && (r_perf_bubble != '1)) begin
                r_perf_bubble <= r_perf_bubble + 1'b1;
            end
        end
    end

    assign perf_stall  = r_perf_stall;
    assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2 (RESET_VAL=0) and DEPTH=3 (RESET_VAL=0xDEADBEEF) instances.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic flush;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.WIDTH(32), .DEPTH(2)) b2 ();
    pipe_stage_buf_if #(.WIDTH(32), .DEPTH(3)) b3 ();

`ifdef PIPE_STAGE_PERF_EN
    perf_cnt_t s2, bb2, s3, bb3;
    int        m_stall3  = 0;
    int        m_bubble3 = 0;
`endif

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0)) u_d2 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .bus    (b2)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall  (s2),
        .perf_bubble (bb2)
`endif
    );

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'hDEAD_BEEF)) u_d3 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .bus    (b3)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall  (s3),
        .perf_bubble (bb3)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic v, input logic [31:0] d, input int c);
        chk({tag, "_vld"}, 32'(b2.out_valid), 32'(v));
        chk({tag, "_dat"}, b2.out_data, d);
        chk({tag, "_cnt"}, 32'(b2.count), 32'(c));
    endtask

`ifdef PIPE_STAGE_PERF_EN
    // Independent tally of idle/stall cycles on the DEPTH=3 instance.
    always @(posedge clk) begin
        if (reset) begin
            m_stall3  <= 0;
            m_bubble3 <= 0;
        end else if (enable) begin
            if (b3.in_valid && (b3.count == 2'd3)) m_stall3 <= m_stall3 + 1;
            if ((b3.count == 2'd0) && b3.out_ready) m_bubble3 <= m_bubble3 + 1;
        end
    end
`endif

    logic [31:0] strm [3];

    initial begin
        strm = '{32'h11, 32'h22, 32'h33};
        reset = 1'b1;
        enable = 1'b1;
        flush = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;

        // Reset
        cyc(); cyc();
        chk2("rst", 1'b0, 32'h0, 0);
        chk("rst_dat3", b3.out_data, 32'hDEAD_BEEF);
        reset = 1'b0;
        cyc();
        chk("rst_rdy", 32'(b2.in_ready), 32'd1);

        // Streaming at full throughput
        b2.out_ready = 1'b1;
        b2.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b2.in_data = strm[i];
            cyc();
            chk2("strm", 1'b1, strm[i], 1);
            chk("strm_rdy", 32'(b2.in_ready), 32'd1);
        end
        b2.in_valid = 1'b0;
        cyc();
        chk2("strm_end", 1'b0, 32'h0, 0);

        // Backpressure
        b2.out_ready = 1'b0;
        b2.in_valid  = 1'b1;
        b2.in_data   = 32'hA;
        cyc();
        chk2("bp_a", 1'b1, 32'hA, 1);
        b2.in_data = 32'hB;
        cyc();
        chk2("bp_b", 1'b1, 32'hA, 2);
        chk("bp_full_rdy", 32'(b2.in_ready), 32'd0);
        b2.in_data = 32'hC;
        cyc();
        chk2("bp_hold", 1'b1, 32'hA, 2);
        b2.out_ready = 1'b1;
        cyc();
        chk2("bp_pop_a", 1'b1, 32'hB, 1);
        cyc();
        chk2("bp_pop_b", 1'b1, 32'hC, 1);
        b2.in_valid = 1'b0;
        cyc();
        chk2("bp_pop_c", 1'b0, 32'h0, 0);

        // Flush with a push offered in the same cycle (count=1 so the push would otherwise land)
        b2.out_ready = 1'b0;
        b2.in_valid  = 1'b1;
        b2.in_data   = 32'h5;
        cyc();
        flush = 1'b1;
        b2.in_data = 32'hDD;
        cyc();
        flush = 1'b0;
        b2.in_valid = 1'b0;
        chk2("fl1", 1'b0, 32'h0, 0);
        // Flush from full
        b2.in_valid = 1'b1;
        b2.in_data  = 32'h1;
        cyc();
        b2.in_data  = 32'h2;
        cyc();
        chk2("fl2_full", 1'b1, 32'h1, 2);
        flush = 1'b1;
        b2.in_data = 32'hDD;
        cyc();
        chk2("fl2", 1'b0, 32'h0, 0);
        flush = 1'b0;
        b2.in_valid = 1'b0;
        b2.out_ready = 1'b1;
        cyc();
        chk2("fl_after", 1'b0, 32'h0, 0);
        b2.out_ready = 1'b0;
        b2.in_valid  = 1'b1;
        b2.in_data   = 32'h77;
        cyc();
        b2.in_valid = 1'b0;
        chk2("fl_push", 1'b1, 32'h77, 1);

        // Freeze, with flush asserted to confirm it is ignored
        enable = 1'b0;
        flush = 1'b1;
        b2.in_valid = 1'b1;
        b2.in_data = 32'h99;
        b2.out_ready = 1'b1;
        #1;
        chk("frz_rdy0", 32'(b2.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk2("frz", 1'b1, 32'h77, 1);
            chk("frz_rdy", 32'(b2.in_ready), 32'd0);
        end
        enable = 1'b1;
        flush = 1'b0;
        b2.in_valid = 1'b0;
        cyc();
        chk2("thaw_pop", 1'b0, 32'h0, 0);
        b2.out_ready = 1'b0;
        b2.in_valid = 1'b1;
        b2.in_data = 32'h88;
        cyc();
        chk2("thaw_push", 1'b1, 32'h88, 1);

        // Reset wins over a concurrent push
        reset = 1'b1;
        b2.in_data = 32'h44;
        cyc();
        chk2("rst_mid", 1'b0, 32'h0, 0);
        reset = 1'b0;
        b2.in_valid = 1'b0;
        cyc();
        chk2("rst_after", 1'b0, 32'h0, 0);

        // DEPTH=3: streaming pairs wrap the pointers several times
        b3.out_ready = 1'b1;
        b3.in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            b3.in_data = 32'(i);
            cyc();
            chk("d3_strm_dat", b3.out_data, 32'(i));
            chk("d3_strm_cnt", 32'(b3.count), 32'd1);
        end
        b3.in_valid = 1'b0;
        cyc();
        chk("d3_idle_dat", b3.out_data, 32'hDEAD_BEEF);
        chk("d3_idle_cnt", 32'(b3.count), 32'd0);

        // DEPTH=3: fill across the wrap boundary, then drain in order
        b3.out_ready = 1'b0;
        b3.in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b3.in_data = 32'h100 + 32'(i);
            cyc();
        end
        chk("d3_full_cnt", 32'(b3.count), 32'd3);
        chk("d3_full_rdy", 32'(b3.in_ready), 32'd0);
        chk("d3_full_dat", b3.out_data, 32'h101);
        b3.in_data = 32'h1FF;
        cyc();
        chk("d3_stall_cnt", 32'(b3.count), 32'd3);
        b3.in_valid  = 1'b0;
        b3.out_ready = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            cyc();
            chk("d3_drain_dat", b3.out_data, 32'h100 + 32'(i));
        end
        cyc();
        chk("d3_drain_cnt", 32'(b3.count), 32'd0);
        chk("d3_drain_vld", 32'(b3.out_valid), 32'd0);
        cyc();
        cyc();

`ifdef PIPE_STAGE_PERF_EN
        chk("perf_bubble3", bb3, 32'(m_bubble3));
        chk("perf_stall3", s3, 32'(m_stall3));
        chk("perf_stall3_nz", 32'(s3 != 0), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
